// File: rtl/duck_flight_ctrl.sv
// Duck flight controller: launch, bounce flight, escape, shot and fall.
// Position, pose and completion pulses advance on a synchronised frame tick.
module duck_flight_ctrl #(
   parameter logic [9:0]  X_MAX      = 10'd601,
   parameter logic [9:0]  Y_MAX      = 10'd400,
   parameter logic [9:0]  STEP       = 10'd2,
   parameter logic [9:0]  FALL_STEP  = 10'd4,
   parameter int          FLY_TICKS  = 300,
   parameter int          SHOT_TICKS = 30,
   parameter int          ANIM_TICKS = 8,
   parameter logic [18:0] SPR_FLY_A  = 19'd550,
   parameter logic [18:0] SPR_FLY_B  = 19'd569,
   parameter logic [18:0] SPR_SHOT   = 19'd588,
   parameter logic [18:0] SPR_FALL   = 19'd607
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic        launch,
   input  logic [9:0]  start_x,
   input  logic        dir_left,
   input  logic        hit,
   output logic [9:0]  Duck_X_Pos,
   output logic [9:0]  Duck_Y_Pos,
   output logic [18:0] sprite_base,
   output logic        duck_visible,
   output logic        escaped,
   output logic        fallen
);

   typedef enum logic [2:0] {IDLE, FLY, ESCAPE, SHOT, FALL} state_t;

   localparam logic [15:0] FLY_LAST  = 16'(FLY_TICKS - 1);
   localparam logic [15:0] SHOT_LAST = 16'(SHOT_TICKS - 1);
   localparam logic [15:0] ANIM_LAST = 16'(ANIM_TICKS - 1);
   localparam logic signed [10:0] STEP_S = $signed({1'b0, STEP});
   localparam logic signed [10:0] XMAX_S = $signed({1'b0, X_MAX});
   localparam logic signed [10:0] YMAX_S = $signed({1'b0, Y_MAX});

   state_t state_q, state_n;
   logic fs1, fs2, fs3, tick;
   logic dx_neg_q, dx_neg_n, dy_neg_q, dy_neg_n;
   logic [15:0] fly_q, fly_n, shot_q, shot_n, anim_q, anim_n;
   logic pose_q, pose_n, pend_q, pend_n, hit_now;
   logic [9:0] x_n, y_n;
   logic [18:0] spr_n;
   logic vis_n, esc_n, fal_n;
   logic signed [10:0] nx, ny;

   // Bring frame_clk into the Clk domain and detect its rising edge
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fs1 <= 1'b0;
         fs2 <= 1'b0;
         fs3 <= 1'b0;
      end else begin
         fs1 <= frame_clk;
         fs2 <= fs1;
         fs3 <= fs2;
      end
   end

   assign tick = fs2 & ~fs3;

   // State, position, counters and registered outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         Duck_X_Pos   <= 10'd320;
         Duck_Y_Pos   <= 10'd240;
         dx_neg_q     <= 1'b0;
         dy_neg_q     <= 1'b1;
         fly_q        <= '0;
         shot_q       <= '0;
         anim_q       <= '0;
         pose_q       <= 1'b0;
         pend_q       <= 1'b0;
         sprite_base  <= SPR_FLY_A;
         duck_visible <= 1'b0;
         escaped      <= 1'b0;
         fallen       <= 1'b0;
      end else begin
         state_q      <= state_n;
         Duck_X_Pos   <= x_n;
         Duck_Y_Pos   <= y_n;
         dx_neg_q     <= dx_neg_n;
         dy_neg_q     <= dy_neg_n;
         fly_q        <= fly_n;
         shot_q       <= shot_n;
         anim_q       <= anim_n;
         pose_q       <= pose_n;
         pend_q       <= pend_n;
         sprite_base  <= spr_n;
         duck_visible <= vis_n;
         escaped      <= esc_n;
         fallen       <= fal_n;
      end
   end

   // Next-state, motion, bounce and pose selection
   always_comb begin
      state_n  = state_q;
      x_n      = Duck_X_Pos;
      y_n      = Duck_Y_Pos;
      dx_neg_n = dx_neg_q;
      dy_neg_n = dy_neg_q;
      fly_n    = fly_q;
      shot_n   = shot_q;
      anim_n   = anim_q;
      pose_n   = pose_q;
      pend_n   = pend_q;
      esc_n    = 1'b0;
      fal_n    = 1'b0;
      hit_now  = pend_q | hit;
      nx = $signed({1'b0, Duck_X_Pos}) + (dx_neg_q ? -STEP_S : STEP_S);
      ny = $signed({1'b0, Duck_Y_Pos}) + (dy_neg_q ? -STEP_S : STEP_S);

      unique case (state_q)
         IDLE: begin
            pend_n = 1'b0;
            if (launch) begin
               state_n  = FLY;
               x_n      = (start_x > X_MAX) ? X_MAX : start_x;
               y_n      = Y_MAX;
               dx_neg_n = dir_left;
               dy_neg_n = 1'b1;
               fly_n    = '0;
               shot_n   = '0;
               anim_n   = '0;
               pose_n   = 1'b0;
            end
         end
         FLY, ESCAPE: begin
            if (hit) pend_n = 1'b1;
            if (tick) begin
               if (anim_q == ANIM_LAST) begin
                  anim_n = '0;
                  pose_n = ~pose_q;
               end else begin
                  anim_n = anim_q + 16'd1;
               end
               if (hit_now) begin
                  state_n = SHOT;
                  pend_n  = 1'b0;
                  shot_n  = '0;
               end else if (state_q == FLY) begin
                  if (nx[10]) begin
                     x_n      = '0;
                     dx_neg_n = ~dx_neg_q;
                  end else if (nx > XMAX_S) begin
                     x_n      = X_MAX;
                     dx_neg_n = ~dx_neg_q;
                  end else begin
                     x_n = nx[9:0];
                  end
                  if (ny[10]) begin
                     y_n      = '0;
                     dy_neg_n = ~dy_neg_q;
                  end else if (ny > YMAX_S) begin
                     y_n      = Y_MAX;
                     dy_neg_n = ~dy_neg_q;
                  end else begin
                     y_n = ny[9:0];
                  end
                  if (fly_q == FLY_LAST) state_n = ESCAPE;
                  else fly_n = fly_q + 16'd1;
               end else if (Duck_Y_Pos <= STEP) begin
                  y_n     = '0;
                  esc_n   = 1'b1;
                  state_n = IDLE;
               end else begin
                  y_n = Duck_Y_Pos - STEP;
               end
            end
         end
         SHOT: begin
            pend_n = 1'b0;
            if (tick) begin
               if (shot_q == SHOT_LAST) state_n = FALL;
               else shot_n = shot_q + 16'd1;
            end
         end
         FALL: begin
            pend_n = 1'b0;
            if (tick) begin
               if (Duck_Y_Pos >= Y_MAX - FALL_STEP) begin
                  y_n     = Y_MAX;
                  fal_n   = 1'b1;
                  state_n = IDLE;
               end else begin
                  y_n = Duck_Y_Pos + FALL_STEP;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      vis_n = (state_n != IDLE);
      unique case (state_n)
         FLY, ESCAPE: spr_n = pose_n ? SPR_FLY_B : SPR_FLY_A;
         SHOT:        spr_n = SPR_SHOT;
         FALL:        spr_n = SPR_FALL;
         default:     spr_n = SPR_FLY_A;
      endcase
   end

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Scoreboard bench for duck_flight_ctrl: directed launches, bounces,
// escape, shot/fall and reset abort with hand-computed positions.
module tb_duck_flight_ctrl;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_clk = 1'b0;
   logic        launch = 1'b0;
   logic [9:0]  start_x = '0;
   logic        dir_left = 1'b0;
   logic        hit = 1'b0;
   logic [9:0]  Duck_X_Pos, Duck_Y_Pos;
   logic [18:0] sprite_base;
   logic        duck_visible, escaped, fallen;

   duck_flight_ctrl dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
      .launch(launch), .start_x(start_x), .dir_left(dir_left),
      .hit(hit), .Duck_X_Pos(Duck_X_Pos), .Duck_Y_Pos(Duck_Y_Pos),
      .sprite_base(sprite_base), .duck_visible(duck_visible),
      .escaped(escaped), .fallen(fallen)
   );

   always #10 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [9:0]  x, y;
      logic [18:0] spr;
      logic        vis, esc, fal;
      string       name;
   } exp_t;

   exp_t expq[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic expect_at(input int due, input logic [9:0] x, y,
                            input logic [18:0] spr, input logic vis,
                            input logic esc, input logic fal,
                            input string name);
      exp_t e;
      e.due = due; e.x = x; e.y = y; e.spr = spr;
      e.vis = vis; e.esc = esc; e.fal = fal; e.name = name;
      expq.push_back(e);
   endtask

   // Monitor: compare every due expectation; flag any unexpected pulse
   always @(negedge Clk) begin
      exp_t e;
      bit matched;
      matched = 1'b0;
      while (expq.size() > 0 && expq[0].due <= cyc) begin
         e = expq.pop_front();
         n_vec++;
         if (e.due != cyc || Duck_X_Pos !== e.x || Duck_Y_Pos !== e.y ||
             sprite_base !== e.spr || duck_visible !== e.vis ||
             escaped !== e.esc || fallen !== e.fal) begin
            n_err++;
            $display("FAIL %s: got x=%0d y=%0d spr=%0d vis=%b esc=%b fal=%b, want x=%0d y=%0d spr=%0d vis=%b esc=%b fal=%b (due %0d, at %0d)",
                     e.name, Duck_X_Pos, Duck_Y_Pos, sprite_base,
                     duck_visible, escaped, fallen, e.x, e.y, e.spr,
                     e.vis, e.esc, e.fal, e.due, cyc);
         end
         if (e.due == cyc) matched = 1'b1;
      end
      if (!matched && (escaped || fallen)) begin
         n_vec++;
         n_err++;
         $display("FAIL stray_pulse: got esc=%b fal=%b at cycle %0d, want none",
                  escaped, fallen, cyc);
      end
   end

   task automatic frame_pulse();
      frame_clk = 1'b1;
      repeat (3) @(posedge Clk);
      #1 frame_clk = 1'b0;
      repeat (3) @(posedge Clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
         frame_pulse();
      end
   endtask

   task automatic tick_chk(input logic [9:0] x, y, input logic [18:0] spr,
                           input logic vis, esc, fal, input string name);
      @(posedge Clk);
      #1;
      expect_at(cyc + 3, x, y, spr, vis, esc, fal, name);
      frame_pulse();
   endtask

   task automatic rst_chk(input bit release_after, input string name);
      @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      launch  = 1'b0;
      hit     = 1'b0;
      expect_at(cyc, 10'd320, 10'd240, 19'd550, 1'b0, 1'b0, 1'b0, name);
      repeat (2) @(posedge Clk);
      if (release_after) #1 Reset_n = 1'b1;
   endtask

   task automatic launch_chk(input bit rel, input logic [9:0] sx,
                             input logic dl, input logic [9:0] x, y,
                             input logic [18:0] spr, input logic vis,
                             input string name);
      @(posedge Clk);
      #1;
      if (rel) Reset_n = 1'b1;
      launch   = 1'b1;
      start_x  = sx;
      dir_left = dl;
      expect_at(cyc + 1, x, y, spr, vis, 1'b0, 1'b0, name);
      @(posedge Clk);
      #1 launch = 1'b0;
   endtask

   task automatic hit_pulse();
      @(posedge Clk);
      #1 hit = 1'b1;
      @(posedge Clk);
      #1 hit = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending",
               expq.size());
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge Clk);

      // Basic flight right/up
      rst_chk(1, "reset_a");
      launch_chk(0, 10'd100, 1'b0, 10'd100, 10'd400, 19'd550, 1'b1, "launch_100");
      tick_chk(10'd102, 10'd398, 19'd550, 1, 0, 0, "fly_t1");
      tick_chk(10'd104, 10'd396, 19'd550, 1, 0, 0, "fly_t2");
      tick_chk(10'd106, 10'd394, 19'd550, 1, 0, 0, "fly_t3");
      launch_chk(0, 10'd500, 1'b1, 10'd106, 10'd394, 19'd550, 1'b1, "launch_ignored");

      // Launch clamp and right-wall bounce
      rst_chk(1, "reset_b");
      launch_chk(0, 10'd1023, 1'b0, 10'd601, 10'd400, 19'd550, 1'b1, "launch_clamp");
      tick_chk(10'd601, 10'd398, 19'd550, 1, 0, 0, "clamp_t1");
      rst_chk(1, "reset_c");
      launch_chk(0, 10'd600, 1'b0, 10'd600, 10'd400, 19'd550, 1'b1, "launch_600");
      tick_chk(10'd601, 10'd398, 19'd550, 1, 0, 0, "bounce_t1");
      tick_chk(10'd599, 10'd396, 19'd550, 1, 0, 0, "bounce_t2");
      tick_chk(10'd597, 10'd394, 19'd550, 1, 0, 0, "bounce_t3");

      // Full flight, left/top bounces, timeout and escape
      rst_chk(1, "reset_d");
      launch_chk(0, 10'd300, 1'b1, 10'd300, 10'd400, 19'd550, 1'b1, "launch_300l");
      ticks(149);
      tick_chk(10'd0,   10'd100, 19'd550, 1, 0, 0, "esc_t150");
      tick_chk(10'd0,   10'd98,  19'd550, 1, 0, 0, "esc_t151_lbounce");
      tick_chk(10'd2,   10'd96,  19'd569, 1, 0, 0, "esc_t152");
      ticks(47);
      tick_chk(10'd98,  10'd0,   19'd569, 1, 0, 0, "esc_t200");
      tick_chk(10'd100, 10'd0,   19'd569, 1, 0, 0, "esc_t201_tbounce");
      tick_chk(10'd102, 10'd2,   19'd569, 1, 0, 0, "esc_t202");
      ticks(97);
      tick_chk(10'd298, 10'd198, 19'd569, 1, 0, 0, "esc_t300");
      tick_chk(10'd298, 10'd196, 19'd569, 1, 0, 0, "escape_k1");
      ticks(96);
      tick_chk(10'd298, 10'd2,   19'd569, 1, 0, 0, "escape_k98");
      tick_chk(10'd298, 10'd0,   19'd550, 0, 1, 0, "escape_done");
      tick_chk(10'd298, 10'd0,   19'd550, 0, 0, 0, "idle_hold");
      hit_pulse();
      tick_chk(10'd298, 10'd0,   19'd550, 0, 0, 0, "idle_hit_ignored");
      launch_chk(0, 10'd10, 1'b0, 10'd10, 10'd400, 19'd550, 1'b1, "launch_after_hit");
      tick_chk(10'd12, 10'd398, 19'd550, 1, 0, 0, "no_stale_hit");

      // Shot at Y=300, frozen, then fall to ground
      rst_chk(1, "reset_e");
      launch_chk(0, 10'd100, 1'b0, 10'd100, 10'd400, 19'd550, 1'b1, "launch_shot");
      ticks(49);
      tick_chk(10'd200, 10'd300, 19'd550, 1, 0, 0, "shot_pre_t50");
      hit_pulse();
      tick_chk(10'd200, 10'd300, 19'd588, 1, 0, 0, "shot_enter");
      ticks(28);
      tick_chk(10'd200, 10'd300, 19'd588, 1, 0, 0, "shot_hold29");
      tick_chk(10'd200, 10'd300, 19'd607, 1, 0, 0, "fall_enter");
      tick_chk(10'd200, 10'd304, 19'd607, 1, 0, 0, "fall_1");
      tick_chk(10'd200, 10'd308, 19'd607, 1, 0, 0, "fall_2");
      ticks(21);
      tick_chk(10'd200, 10'd396, 19'd607, 1, 0, 0, "fall_24");
      tick_chk(10'd200, 10'd400, 19'd550, 0, 0, 1, "fall_ground");

      // Hit with timeout on the same tick, then reset during fall
      rst_chk(1, "reset_f");
      launch_chk(0, 10'd300, 1'b1, 10'd300, 10'd400, 19'd550, 1'b1, "launch_race");
      ticks(298);
      tick_chk(10'd296, 10'd196, 19'd569, 1, 0, 0, "race_t299");
      hit_pulse();
      tick_chk(10'd296, 10'd196, 19'd588, 1, 0, 0, "race_shot_wins");
      ticks(29);
      tick_chk(10'd296, 10'd196, 19'd607, 1, 0, 0, "race_fall");
      tick_chk(10'd296, 10'd200, 19'd607, 1, 0, 0, "race_fall_1");
      tick_chk(10'd296, 10'd204, 19'd607, 1, 0, 0, "race_fall_2");
      rst_chk(0, "reset_in_fall");
      launch_chk(1, 10'd50, 1'b1, 10'd50, 10'd400, 19'd550, 1'b1, "launch_on_release");
      tick_chk(10'd48, 10'd398, 19'd550, 1, 0, 0, "post_reset_t1");

      repeat (10) @(posedge Clk);
      if (expq.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/duck_flight_ctrl.md
DUCK_FLIGHT_CTRL -- requirements
Module: duck_flight_ctrl

Interface
REQ-001 SHALL have parameter X_MAX, default 10'd601, rightmost legal Duck_X_Pos.
REQ-002 SHALL have parameter Y_MAX, default 10'd400, ground line and lowest legal Duck_Y_Pos; topmost legal position is 0.
REQ-003 SHALL have parameter STEP, default 10'd2, flight step per frame tick on each axis.
REQ-004 SHALL have parameter FALL_STEP, default 10'd4, fall step per frame tick.
REQ-005 SHALL have parameters FLY_TICKS (default 300), SHOT_TICKS (default 30) and ANIM_TICKS (default 8): flight timeout, shot hold time and wing-flap period, all in frame ticks.
REQ-006 SHALL have parameters SPR_FLY_A (550), SPR_FLY_B (569), SPR_SHOT (588) and SPR_FALL (607), 19-bit sprite ROM base addresses.
REQ-007 Clk  in  1  system clock, 50 MHz, sole clock.
REQ-008 Reset_n  in  1  asynchronous, active-low reset.
REQ-009 frame_clk  in  1  frame strobe (~60 Hz), asynchronous to Clk.
REQ-010 launch  in  1  request for a new duck; single-Clk pulse or level.
REQ-011 start_x  in  10  launch X position.
REQ-012 dir_left  in  1  launch horizontal direction: 1 = left, 0 = right.
REQ-013 hit  in  1  shot-landed pulse, one Clk wide.
REQ-014 Duck_X_Pos, Duck_Y_Pos  out  10 each  sprite top-left position.
REQ-015 sprite_base  out  19  ROM base address of the current pose.
REQ-016 duck_visible  out  1  high in every state except IDLE.
REQ-017 escaped, fallen  out  1 each  single-Clk completion pulses.

Function
REQ-018 SHALL synchronise frame_clk through two flops and form tick, a single-Clk pulse on each rising edge; tick-driven output updates SHALL be visible 3 Clk after the frame_clk rise.
REQ-019 SHALL implement the states IDLE, FLY, ESCAPE, SHOT and FALL.
REQ-020 IDLE: launch SHALL be accepted on the next Clk edge, independent of tick.
REQ-021 On launch acceptance: X = start_x clamped to X_MAX; Y = Y_MAX; dx = -1 if dir_left, else +1; dy = -1; counters cleared; state FLY.
REQ-022 launch SHALL be ignored outside IDLE.
REQ-023 FLY, per tick: X += dx*STEP and Y += dy*STEP, computed in 11-bit signed arithmetic.
REQ-024 FLY bounce: if the new X < 0 or > X_MAX, the position SHALL clamp to the violated bound and dx SHALL negate in the same tick; Y behaves the same against 0 and Y_MAX.
REQ-025 FLY timeout: after FLY_TICKS ticks in FLY, the state SHALL become ESCAPE.
REQ-026 ESCAPE, per tick: X held, Y -= STEP clamped at 0; when Y reaches 0, escaped SHALL pulse on that edge and the state SHALL become IDLE.
REQ-027 hit SHALL set a pending flag on any Clk while in FLY or ESCAPE; the flag SHALL be consumed at the next tick, entering SHOT with position frozen.
REQ-028 hit SHALL be ignored, and the pending flag cleared, in IDLE, SHOT and FALL.
REQ-029 Pending hit and FLY timeout on the same tick: SHOT SHALL win.
REQ-030 SHOT: position held for SHOT_TICKS ticks, then the state SHALL become FALL.
REQ-031 FALL, per tick: Y += FALL_STEP clamped at Y_MAX; when Y reaches Y_MAX, fallen SHALL pulse and the state SHALL become IDLE.
REQ-032 Wing-flap counter SHALL count ticks modulo ANIM_TICKS in FLY and ESCAPE; the pose bit SHALL toggle on wrap and clear on launch.
REQ-033 sprite_base SHALL be registered:
  - FLY/ESCAPE: SPR_FLY_A when pose bit = 0, SPR_FLY_B when 1.
  - SHOT: SPR_SHOT.
  - FALL: SPR_FALL.
  - IDLE: SPR_FLY_A.
REQ-034 All outputs SHALL be registered; position SHALL hold in IDLE.

Reset
REQ-035 Reset_n low SHALL immediately force:
  - state IDLE, Duck_X_Pos 320, Duck_Y_Pos 240, dx +1, dy -1;
  - sprite_base SPR_FLY_A, duck_visible 0, escaped 0, fallen 0;
  - counters, pose bit, hit flag and frame_clk synchronisers 0.
REQ-036 Reset asserted mid-flight SHALL abort without an escaped or fallen pulse; after release, the block SHALL accept launch on the first Clk.

Verification
REQ-037 Launch, start_x=100, dir_left=0, 3 ticks -> X=106, Y=394, duck_visible=1, sprite_base=550.
REQ-038 Right-wall bounce: start_x=600, dir_left=0 -> tick1 X=601 (clamped), dx=-1; tick2 X=599.
REQ-039 FLY_TICKS ticks with no hit -> ESCAPE; Y drops 2 per tick to 0; one escaped pulse; IDLE; duck_visible=0.
REQ-040 hit pulse between ticks in FLY at Y=300 -> next tick SHOT, sprite_base=588, position frozen 30 ticks; FALL with sprite_base=607, Y 304, 308, ... clamped at 400; one fallen pulse.
REQ-041 hit on the same tick as the FLY timeout -> SHOT, not ESCAPE; hit while in IDLE -> no state change.
REQ-042 Reset_n low during FALL -> X=320, Y=240, IDLE, no fallen pulse; launch on the first Clk after release is accepted.
